zoom_nn_2x: RTL
===============

# zoom_nn_2x

Nearest-neighbour 2x upscaler placed directly downstream of the `save_image` pixel ROM. On a `start` pulse it walks the destination raster of size (2·img_width) × (2·img_height). For each destination pixel it drives the source coordinates `x`, `y` into the ROM and captures the returned pixel. It then presents the pixel on a valid/ready output stream, tagged with its destination coordinates.

## Interface

Parameters:
- `img_width`, default 4: source image width in pixels; legal range 1..16.
- `img_height`, default 4: source image height in pixels; legal range 1..16.

Ports:
- `clk`, input, 1 bit: single clock; all state changes on the rising edge.
- `reset`, input, 1 bit: asynchronous, active-high reset.
- `start`, input, 1 bit: begin one frame; sampled only in IDLE.
- `x`, output, 4 bits: source column to the ROM.
- `y`, output, 4 bits: source row to the ROM.
- `pixel_in`, input, 8 bits: ROM pixel data, combinational from `x`/`y`.
- `pixel_in_valid`, input, 1 bit: ROM data valid.
- `out_pixel`, output, 8 bits: upscaled pixel.
- `out_x`, output, 5 bits: destination column of `out_pixel`.
- `out_y`, output, 5 bits: destination row of `out_pixel`.
- `out_valid`, output, 1 bit: output beat valid.
- `out_ready`, input, 1 bit: downstream accepts the beat.
- `busy`, output, 1 bit: frame in progress.
- `done`, output, 1 bit: one-cycle pulse after the last beat is accepted.

## Operation

- Destination counters:
  - `dx` counts 0..2·img_width−1 and `dy` counts 0..2·img_height−1, both 5 bits.
  - The source address is `x = dx[4:1]`, `y = dy[4:1]`, driven combinationally from the counter registers.
- States and transitions:
  - IDLE: `start`=1 → FETCH with `dx`=`dy`=0. Otherwise stay.
  - FETCH: if `pixel_in_valid`=1, load `out_pixel`←`pixel_in`, `out_x`←`dx`, `out_y`←`dy`, set `out_valid`=1, and go to EMIT. If 0, stay in FETCH with the address held.
  - EMIT: hold all output registers until `out_valid`&&`out_ready`. On that handshake, clear `out_valid` and then:
    - If `dx`=2·img_width−1 and `dy`=2·img_height−1, go to DONE.
    - Otherwise, if `dx` is at its maximum, set `dx`=0 and increment `dy`; else increment `dx`. Then go to FETCH.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- `busy`=1 in FETCH and EMIT, and 0 in IDLE and DONE.
- `start` is ignored outside IDLE. `start` held high in IDLE after DONE begins a new frame.
- `out_pixel`, `out_x` and `out_y` are stable while `out_valid`=1 and `out_ready`=0 (standard AXI-style rule: no retraction).
- No arithmetic on pixel values: data passes through bit-exact.

## Timing

- Reset (asynchronous, immediate) forces:
  - state IDLE;
  - `dx`=`dy`=0, hence `x`=`y`=0;
  - `out_pixel`=0, `out_x`=`out_y`=0;
  - `out_valid`=0, `busy`=0, `done`=0.
- Reset mid-frame aborts the frame. No `done` pulse is produced, and the in-flight beat is dropped.
- Latency: `start` sampled at edge E0 → FETCH in the next cycle → `out_valid`=1 after edge E1.
- Throughput: 2 cycles per beat at best (FETCH + EMIT), with `out_ready` and `pixel_in_valid` tied high.
- Full 4×4 frame with `out_ready`=1:
  - 64 beats;
  - last handshake at E128;
  - `done`=1 during the cycle after E128;
  - IDLE after E129.
- Each cycle with `out_ready`=0 in EMIT adds exactly one cycle.
- Each cycle with `pixel_in_valid`=0 in FETCH adds exactly one cycle.

## Structure

- Shared package `zoom_pkg`:
  - state encoding (IDLE, FETCH, EMIT, DONE);
  - `PIXEL_W`=8;
  - `COORD_W`=4;
  - `DCOORD_W`=5;
  - `SCALE`=2.
- One natural sub-module: `dest_counter`, the dx/dy raster counter.
  - Inputs: `clear`, `advance`.
  - Outputs: `last` flag and the counter values.
- The FSM and output register live in `zoom_nn_2x`.

## Test plan

- Reset, then `start` pulse with the default 4×4 ROM contents and `out_ready`=1. Expected:
  - beats (0,0)=0, (1,0)=0, (2,0)=64, (0,2)=32, (7,7)=255;
  - 64 beats total;
  - `done` pulse one cycle after the 64th handshake.
- `out_ready` held 0 for 5 cycles on beat (2,0): `out_valid`, `out_pixel`=64 and `out_x`=2 stay constant throughout; the frame completes 5 cycles late.
- `pixel_in_valid` low for 3 cycles during FETCH of (3,1): `x`=1, `y`=0 stay held; the beat is emitted with `out_pixel`=64 three cycles late.
- `start` asserted while `busy`=1: ignored; beat count remains 64 and only one `done` pulse occurs.
- Assert `reset` at beat 20 mid-handshake: all outputs read 0 immediately. The next `start` restarts at (0,0) with no `done` from the aborted frame.
- `img_width`=1, `img_height`=1 with a 1-entry ROM value 0xA5: 4 beats at (0,0),(1,0),(0,1),(1,1), all 0xA5, then `done`.

Source files
------------

// File: rtl/zoom_pkg.sv
// zoom_pkg: shared types and constants for the nearest-neighbour 2x upscaler.
//   PIXEL_W  - pixel data width
//   COORD_W  - source (ROM) coordinate width
//   DCOORD_W - destination coordinate width
//   SCALE    - upscale factor in each dimension
//   zoom_state_e - controller state encoding
package zoom_pkg;

    localparam int unsigned PIXEL_W  = 8;
    localparam int unsigned COORD_W  = 4;
    localparam int unsigned DCOORD_W = 5;
    localparam int unsigned SCALE    = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StEmit  = 2'd2,
        StDone  = 2'd3
    } zoom_state_e;

endpackage

// File: rtl/zoom_nn_2x_dest_counter.sv
// dest_counter: destination raster counter for the 2x upscaler.
// Walks dx over 0..dst_width-1 and dy over 0..dst_height-1 in raster order.
//   clk, reset  - clock, asynchronous active-high reset
//   clear       - return both counters to zero (takes priority over advance)
//   advance     - step to the next destination pixel; ignored on the last pixel
//   dx, dy      - current destination column / row
//   last        - current position is the final pixel of the frame
module dest_counter
    import zoom_pkg::*;
#(
    parameter int unsigned dst_width  = 8,
    parameter int unsigned dst_height = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                advance,
    output logic [DCOORD_W-1:0] dx,
    output logic [DCOORD_W-1:0] dy,
    output logic                last
);

    localparam logic [DCOORD_W-1:0] DxMax = DCOORD_W'(dst_width - 1);
    localparam logic [DCOORD_W-1:0] DyMax = DCOORD_W'(dst_height - 1);

    logic [DCOORD_W-1:0] dx_q, dx_d;
    logic [DCOORD_W-1:0] dy_q, dy_d;
    logic                dx_at_max;
    logic                dy_at_max;

    assign dx_at_max = (dx_q == DxMax);
    assign dy_at_max = (dy_q == DyMax);
    assign last      = dx_at_max && dy_at_max;

    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (clear) begin
            dx_d = '0;
            dy_d = '0;
        end else if (advance && !last) begin
            // Counters hold on the final pixel; the next frame clears them.
            if (dx_at_max) begin
                dx_d = '0;
                dy_d = dy_q + DCOORD_W'(1);
            end else begin
                dx_d = dx_q + DCOORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign dx = dx_q;
    assign dy = dy_q;

endmodule

// File: rtl/zoom_nn_2x.sv
// zoom_nn_2x: nearest-neighbour 2x upscaler fed by a combinational pixel ROM.
// On start, walks the (2*img_width) x (2*img_height) destination raster, fetches
// each source pixel at (dx/2, dy/2) and emits it on a valid/ready stream tagged
// with its destination coordinates.
//   clk, reset      - clock, asynchronous active-high reset
//   start           - begin a frame (sampled only when idle)
//   x, y            - source address to the ROM
//   pixel_in        - ROM data for (x, y)
//   pixel_in_valid  - ROM data valid
//   out_pixel       - upscaled pixel
//   out_x, out_y    - destination coordinates of out_pixel
//   out_valid       - output beat valid
//   out_ready       - downstream accepts the beat
//   busy            - frame in progress
//   done            - one-cycle pulse after the last beat is accepted
module zoom_nn_2x
    import zoom_pkg::*;
#(
    parameter int unsigned img_width  = 4,
    parameter int unsigned img_height = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [COORD_W-1:0]  x,
    output logic [COORD_W-1:0]  y,
    input  logic [PIXEL_W-1:0]  pixel_in,
    input  logic                pixel_in_valid,
    output logic [PIXEL_W-1:0]  out_pixel,
    output logic [DCOORD_W-1:0] out_x,
    output logic [DCOORD_W-1:0] out_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

    if (img_width < 1 || img_width > 16) begin : g_bad_width
        $error("zoom_nn_2x: img_width must be in 1..16");
    end
    if (img_height < 1 || img_height > 16) begin : g_bad_height
        $error("zoom_nn_2x: img_height must be in 1..16");
    end

    zoom_state_e         state_q;
    logic [DCOORD_W-1:0] dx;
    logic [DCOORD_W-1:0] dy;
    logic                last;
    logic                cnt_clear;
    logic                cnt_advance;
    logic                handshake;

    assign handshake   = out_valid && out_ready;
    assign cnt_clear   = (state_q == StIdle) && start;
    assign cnt_advance = (state_q == StEmit) && handshake;

    dest_counter #(
        .dst_width  (img_width * SCALE),
        .dst_height (img_height * SCALE)
    ) u_dest_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .dx      (dx),
        .dy      (dy),
        .last    (last)
    );

    // Dropping the LSB of each destination coordinate divides by SCALE = 2.
    assign x = dx[DCOORD_W-1:1];
    assign y = dy[DCOORD_W-1:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            out_pixel <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StFetch;
                        busy    <= 1'b1;
                    end
                end
                StFetch: begin
                    // Address is held by the counter until the ROM answers.
                    if (pixel_in_valid) begin
                        out_pixel <= pixel_in;
                        out_x     <= dx;
                        out_y     <= dy;
                        out_valid <= 1'b1;
                        state_q   <= StEmit;
                    end
                end
                StEmit: begin
                    // Output registers are untouched until the beat is taken.
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (last) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_q <= StFetch;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
